// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen
//   Video timing generator feeding the HDMI line buffer (256->16 unpacker).
//   Produces hdmi_Pre_de / hdmi_Pre_hsync / hdmi_Pre_vsync for the buffer.
//   A run is only started once the buffer reports itself primed
//   (hdmi_start), and a run always begins and ends on a whole-frame
//   boundary so the buffer never sees a partial frame.
//
//   Optional feature macro: HDMI_TG_PATTERN_EN
//     defined   -> pattern_data carries 8 vertical RGB565 colour bars
//     undefined -> pattern_data is tied to 16'h0000, no bar logic
//
// Ports
//   hdmi_clk        in   1      pixel clock
//   sync_rst        in   1      synchronous reset, active-high
//   tg_en           in   1      run request (level)
//   hdmi_start      in   1      line buffer primed (level)
//   hdmi_Pre_de     out  1      active video
//   hdmi_Pre_hsync  out  1      horizontal sync, HS_POL when active
//   hdmi_Pre_vsync  out  1      vertical sync, VS_POL when active
//   frame_start     out  1      single-cycle pulse on the first cycle of a frame
//   pix_x           out  CNT_W  active column, 0 when de=0
//   pix_y           out  CNT_W  active row, 0 when de=0
//   tg_busy         out  1      1 while in ARM/RUN/DRAIN
//   pattern_data    out  16     RGB565 test pattern, 0 when de=0
//
// Pipeline: counters/FSM (p0) -> registered output decode (p1).
// Every output carries exactly one clock of latency from the counters.

module hdmi_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12
) (
  input  logic             hdmi_clk,
  input  logic             sync_rst,
  input  logic             tg_en,
  input  logic             hdmi_start,
  output logic             hdmi_Pre_de,
  output logic             hdmi_Pre_hsync,
  output logic             hdmi_Pre_vsync,
  output logic             frame_start,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             tg_busy,
  output logic [15:0]      pattern_data
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // ---------------------------------------------------------------
  // Stage p0: FSM and h/v counters
  // ---------------------------------------------------------------
  state_t           r_state_p0;
  logic [CNT_W-1:0] r_h_cnt_p0;
  logic [CNT_W-1:0] r_v_cnt_p0;
  logic             r_busy_p0;

  logic             w_run;
  logic             w_h_last;
  logic             w_v_last;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_de;

  assign w_run    = (r_state_p0 == RUN) || (r_state_p0 == DRAIN);
  assign w_h_last = (r_h_cnt_p0 == H_LAST);
  assign w_v_last = (r_v_cnt_p0 == V_LAST);
  assign w_h_next = w_h_last ? '0 : r_h_cnt_p0 + CNT_W'(1);
  assign w_v_next = !w_h_last ? r_v_cnt_p0 :
                    (w_v_last ? '0 : r_v_cnt_p0 + CNT_W'(1));

  assign w_de = (r_h_cnt_p0 >= H_ACT_S) && (r_h_cnt_p0 < H_ACT_E) &&
                (r_v_cnt_p0 >= V_ACT_S) && (r_v_cnt_p0 < V_ACT_E);

  // tg_busy is driven from the next state so it tracks the state itself.
  always_ff @(posedge hdmi_clk) begin
    if (sync_rst) begin
      r_state_p0 <= IDLE;
      r_h_cnt_p0 <= '0;
      r_v_cnt_p0 <= '0;
      r_busy_p0  <= 1'b0;
    end else begin
      case (r_state_p0)
        IDLE: begin
          r_h_cnt_p0 <= '0;
          r_v_cnt_p0 <= '0;
          if (tg_en) begin
            r_state_p0 <= ARM;
            r_busy_p0  <= 1'b1;
          end else begin
            r_busy_p0  <= 1'b0;
          end
        end
        ARM: begin
          r_h_cnt_p0 <= '0;
          r_v_cnt_p0 <= '0;
          if (!tg_en) begin
            r_state_p0 <= IDLE;
            r_busy_p0  <= 1'b0;
          end else begin
            if (hdmi_start) r_state_p0 <= RUN;
            r_busy_p0 <= 1'b1;
          end
        end
        RUN: begin
          r_h_cnt_p0 <= w_h_next;
          r_v_cnt_p0 <= w_v_next;
          r_busy_p0  <= 1'b1;
          if (!tg_en) r_state_p0 <= DRAIN;
        end
        DRAIN: begin
          r_h_cnt_p0 <= w_h_next;
          r_v_cnt_p0 <= w_v_next;
          // A renewed run request wins over the end-of-frame exit.
          if (tg_en) begin
            r_state_p0 <= RUN;
            r_busy_p0  <= 1'b1;
          end else if (w_h_last && w_v_last) begin
            r_state_p0 <= IDLE;
            r_busy_p0  <= 1'b0;
          end else begin
            r_busy_p0  <= 1'b1;
          end
        end
        default: begin
          r_state_p0 <= IDLE;
          r_h_cnt_p0 <= '0;
          r_v_cnt_p0 <= '0;
          r_busy_p0  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HDMI_TG_PATTERN_EN
  // Bar tracking runs beside the counters so no divider is needed:
  // r_bar_x_p0 counts pixels inside the current bar, r_bar_i_p0 is the
  // bar index valid for the current h count. Index saturates at 8
  // (black) for any remainder pixels when H_ACTIVE is not a multiple of 8.
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] r_bar_x_p0;
  logic [3:0]       r_bar_i_p0;
  logic [CNT_W-1:0] w_h_adv;
  logic [15:0]      w_pat;
  logic [15:0]      r_pattern_p1;

  function automatic logic [15:0] bar_colour(input logic [3:0] idx);
    logic [15:0] c;
    case (idx)
      4'd0:    c = 16'hFFFF;
      4'd1:    c = 16'hFFE0;
      4'd2:    c = 16'h07FF;
      4'd3:    c = 16'h07E0;
      4'd4:    c = 16'hF81F;
      4'd5:    c = 16'hF800;
      4'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Value the h counter takes after this edge.
  assign w_h_adv = (sync_rst || !w_run) ? '0 : w_h_next;
  assign w_pat   = (w_run && w_de) ? bar_colour(r_bar_i_p0) : 16'h0000;

  always_ff @(posedge hdmi_clk) begin
    if (w_h_adv == H_ACT_S) begin
      r_bar_x_p0 <= '0;
      r_bar_i_p0 <= 4'd0;
    end else if (r_bar_x_p0 == BAR_LAST) begin
      r_bar_x_p0 <= '0;
      if (r_bar_i_p0 != 4'd8) r_bar_i_p0 <= r_bar_i_p0 + 4'd1;
    end else begin
      r_bar_x_p0 <= r_bar_x_p0 + CNT_W'(1);
    end
  end

  always_ff @(posedge hdmi_clk) begin
    if (sync_rst) r_pattern_p1 <= 16'h0000;
    else          r_pattern_p1 <= w_pat;
  end

  assign pattern_data = r_pattern_p1;
`else
  assign pattern_data = 16'h0000;
`endif

  // ---------------------------------------------------------------
  // Stage p1: registered output decode
  // ---------------------------------------------------------------
  logic             r_de_p1;
  logic             r_hsync_p1;
  logic             r_vsync_p1;
  logic             r_fstart_p1;
  logic [CNT_W-1:0] r_pix_x_p1;
  logic [CNT_W-1:0] r_pix_y_p1;

  always_ff @(posedge hdmi_clk) begin
    if (sync_rst) begin
      r_de_p1     <= 1'b0;
      r_hsync_p1  <= ~HS_POL;
      r_vsync_p1  <= ~VS_POL;
      r_fstart_p1 <= 1'b0;
      r_pix_x_p1  <= '0;
      r_pix_y_p1  <= '0;
    end else begin
      r_de_p1     <= w_run && w_de;
      r_hsync_p1  <= (w_run && (r_h_cnt_p0 < H_SYNC_E)) ? HS_POL : ~HS_POL;
      r_vsync_p1  <= (w_run && (r_v_cnt_p0 < V_SYNC_E)) ? VS_POL : ~VS_POL;
      r_fstart_p1 <= w_run && (r_h_cnt_p0 == '0) && (r_v_cnt_p0 == '0);
      r_pix_x_p1  <= (w_run && w_de) ? r_h_cnt_p0 - H_ACT_S : '0;
      r_pix_y_p1  <= (w_run && w_de) ? r_v_cnt_p0 - V_ACT_S : '0;
    end
  end

  assign hdmi_Pre_de    = r_de_p1;
  assign hdmi_Pre_hsync = r_hsync_p1;
  assign hdmi_Pre_vsync = r_vsync_p1;
  assign frame_start    = r_fstart_p1;
  assign pix_x          = r_pix_x_p1;
  assign pix_y          = r_pix_y_p1;
  assign tg_busy        = r_busy_p0;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen with a reduced raster:
//   H: sync 2, bp 2, active 16, fp 2 -> 22 clocks/line
//   V: sync 1, bp 1, active 4,  fp 1 -> 7 lines, 154 clocks/frame
// Index t below is the counter position (t = v*22 + h) whose decode is
// visible on the outputs.

module tb_hdmi_timing_gen;

  localparam int HT = 22;
  localparam int FR = 154;

`ifdef HDMI_TG_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] px;
    logic [11:0] py;
    logic        busy;
    logic [15:0] pat;
  } outs_t;

  typedef struct {
    string name;
    logic  rst;
    logic  en;
    logic  st;
    int    n;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        st  = 1'b0;
  logic        de, hs, vs, fs, busy;
  logic [11:0] px, py;
  logic [15:0] pat;

  int n_chk  = 0;
  int n_pass = 0;
  int t_f    = 0;

  always #5 clk = ~clk;

  hdmi_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)
  ) dut (
    .hdmi_clk      (clk),
    .sync_rst      (rst),
    .tg_en         (en),
    .hdmi_start    (st),
    .hdmi_Pre_de   (de),
    .hdmi_Pre_hsync(hs),
    .hdmi_Pre_vsync(vs),
    .frame_start   (fs),
    .pix_x         (px),
    .pix_y         (py),
    .tg_busy       (busy),
    .pattern_data  (pat)
  );

  function automatic outs_t inactive(input logic b);
    outs_t o;
    o = '0;
    o.busy = b;
    return o;
  endfunction

  function automatic logic [15:0] bar_of(input int x);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return bars[x / 2];
  endfunction

  // Reference raster for counter position t (0..FR-1) while running.
  function automatic outs_t model(input int t, input logic b);
    outs_t o;
    int h, v;
    h = t % HT;
    v = t / HT;
    o = '0;
    o.busy = b;
    o.hs   = (h < 2);
    o.vs   = (v < 1);
    o.fs   = (t == 0);
    o.de   = (h >= 4) && (h < 20) && (v >= 2) && (v < 6);
    if (o.de) begin
      o.px = 12'(h - 4);
      o.py = 12'(v - 2);
      if (PAT) o.pat = bar_of(h - 4);
    end
    return o;
  endfunction

  function automatic vec_t mk(input string nm, input logic r, input logic e,
                              input logic s, input int n, input logic d,
                              input logic h, input logic v, input logic f,
                              input int x, input int y, input logic b,
                              input logic [15:0] p);
    vec_t w;
    w.name = nm; w.rst = r; w.en = e; w.st = s; w.n = n;
    w.exp.de = d; w.exp.hs = h; w.exp.vs = v; w.exp.fs = f;
    w.exp.px = 12'(x); w.exp.py = 12'(y); w.exp.busy = b;
    w.exp.pat = PAT ? p : 16'h0000;
    return w;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.de = de; o.hs = hs; o.vs = vs; o.fs = fs;
    o.px = px; o.py = py; o.busy = busy; o.pat = pat;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input outs_t exp);
    outs_t got;
    got = sample();
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0d: got de=%0b hs=%0b vs=%0b fs=%0b px=%0d py=%0d busy=%0b pat=%h, expected de=%0b hs=%0b vs=%0b fs=%0b px=%0d py=%0d busy=%0b pat=%h",
               nm, t_f, got.de, got.hs, got.vs, got.fs, got.px, got.py, got.busy, got.pat,
               exp.de, exp.hs, exp.vs, exp.fs, exp.px, exp.py, exp.busy, exp.pat);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  vec_t vecs [17];

  initial begin
    int de_cnt;
    int fs_cnt;

    //            name           rst en st  n    de hs vs fs px py busy pat
    vecs[0]  = mk("reset",       1, 0, 0,   5,  0, 0, 0, 0, 0, 0, 0, 16'h0000);
    vecs[1]  = mk("idle_start",  0, 0, 1,   3,  0, 0, 0, 0, 0, 0, 0, 16'h0000);
    vecs[2]  = mk("arm_enter",   0, 1, 0,   1,  0, 0, 0, 0, 0, 0, 1, 16'h0000);
    vecs[3]  = mk("arm_wait",    0, 1, 0, 300,  0, 0, 0, 0, 0, 0, 1, 16'h0000);
    vecs[4]  = mk("arm_abort",   0, 0, 0,   1,  0, 0, 0, 0, 0, 0, 0, 16'h0000);
    vecs[5]  = mk("en_st_idle",  0, 1, 1,   1,  0, 0, 0, 0, 0, 0, 1, 16'h0000);
    vecs[6]  = mk("arm_to_run",  0, 1, 1,   1,  0, 0, 0, 0, 0, 0, 1, 16'h0000);
    vecs[7]  = mk("first_out",   0, 1, 0,   1,  0, 1, 1, 1, 0, 0, 1, 16'h0000);
    vecs[8]  = mk("t1",          0, 1, 0,   1,  0, 1, 1, 0, 0, 0, 1, 16'h0000);
    vecs[9]  = mk("hsync_end",   0, 1, 0,   1,  0, 0, 1, 0, 0, 0, 1, 16'h0000);
    vecs[10] = mk("line1_vs_off",0, 1, 0,  20,  0, 1, 0, 0, 0, 0, 1, 16'h0000);
    vecs[11] = mk("first_de",    0, 1, 0,  26,  1, 0, 0, 0, 0, 0, 1, 16'hFFFF);
    vecs[12] = mk("px1",         0, 1, 0,   1,  1, 0, 0, 0, 1, 0, 1, 16'hFFFF);
    vecs[13] = mk("last_px",     0, 1, 0,  14,  1, 0, 0, 0, 15, 0, 1, 16'h0000);
    vecs[14] = mk("de_off_fp",   0, 1, 0,   1,  0, 0, 0, 0, 0, 0, 1, 16'h0000);
    vecs[15] = mk("row3_px9",    0, 1, 0,  59,  1, 0, 0, 0, 9, 3, 1, 16'hF81F);
    vecs[16] = mk("next_frame",  0, 1, 0,  31,  0, 1, 1, 1, 0, 0, 1, 16'h0000);

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      st  = vecs[i].st;
      for (int k = 0; k < vecs[i].n; k++) step();
      chk(vecs[i].name, vecs[i].exp);
    end
    t_f = 0;

    // Two full frames against the reference raster.
    de_cnt = 0;
    fs_cnt = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      step();
      t_f = (t_f + 1) % FR;
      chk("scan", model(t_f, 1'b1));
      if (de) de_cnt++;
      if (fs) fs_cnt++;
    end
    chk_int("de_cycles_2frames", de_cnt, 128);
    chk_int("frame_starts_2frames", fs_cnt, 2);

    // tg_en dropped and re-raised inside a frame: no visible change.
    fs_cnt = 0;
    for (int k = 0; k < FR; k++) begin
      step();
      t_f = (t_f + 1) % FR;
      chk("reraise", model(t_f, 1'b1));
      if (fs) fs_cnt++;
      if (t_f == 50) en = 1'b0;
      if (t_f == 80) en = 1'b1;
    end
    chk_int("reraise_period", fs_cnt, 1);

    // tg_en dropped mid-frame: frame completes, then IDLE.
    de_cnt = 0;
    for (int k = 1; k < FR; k++) begin
      step();
      t_f = k;
      chk("drain", model(t_f, (t_f == FR - 1) ? 1'b0 : 1'b1));
      if (de) de_cnt++;
      if (t_f == 100) en = 1'b0;
    end
    chk_int("drain_de_cycles", de_cnt, 64);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("after_drain", inactive(1'b0));
    end

    // Restart, then sync_rst in the middle of an active line.
    en = 1'b1;
    st = 1'b1;
    step();
    chk("restart_arm", inactive(1'b1));
    step();
    chk("restart_run", inactive(1'b1));
    st = 1'b0;
    for (int k = 0; k <= 76; k++) begin
      step();
      t_f = k;
      chk("pre_rst", model(t_f, 1'b1));
    end
    rst = 1'b1;
    step();
    chk("mid_line_rst", inactive(1'b0));
    rst = 1'b0;
    en  = 1'b0;
    st  = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      chk("post_rst_idle", inactive(1'b0));
    end
    en = 1'b1;
    st = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_arm", inactive(1'b1));
    end
    st = 1'b1;
    step();
    chk("post_rst_run", inactive(1'b1));
    step();
    t_f = 0;
    chk("post_rst_frame", model(0, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
